rtc_bus_arbiter: RTL

Shares the RTC chip's multiplexed address/data bus among up to N_REQ field controllers (seconds, minutes, hours, day, month, year). A round-robin arbiter picks one pending write request. The block then runs a complete write cycle on the bus: an address phase followed by a data phase, with CS/AD/WR/RD strobes generated in sequence. It sits between the per-field counter/register blocks and the top-level RTC pins, and replaces the per-field write timers.

---
 rtl/rtc_pkg.sv | 12 +
 rtl/rtc_bus_arbiter_if.sv | 19 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/rtc_bus_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: bus FSM states, AD phase levels and RTC field register addresses
package rtc_pkg;
    typedef enum logic [2:0] {IDLE, A_SET, A_WR, A_HOLD, D_SET, D_WR, D_HOLD} state_t;
    localparam logic AD_ADDR = 1'b0;
    localparam logic AD_DATA = 1'b1;
    localparam logic [7:0] REG_SEC   = 8'h00;
    localparam logic [7:0] REG_MIN   = 8'h02;
    localparam logic [7:0] REG_HOUR  = 8'h04;
    localparam logic [7:0] REG_DAY   = 8'h07;
    localparam logic [7:0] REG_MONTH = 8'h08;
    localparam logic [7:0] REG_YEAR  = 8'h09;
endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// rtc_bus_arbiter_if: requester handshake plus RTC multiplexed bus pins
interface rtc_bus_arbiter_if #(parameter int N_REQ = 6);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] addr_in;
    logic [8*N_REQ-1:0] data_in;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic [7:0]         bus_out;
    logic               bus_oe;
    logic               CS;
    logic               AD;
    logic               WR;
    logic               RD;
    modport master (output req, addr_in, data_in,
                    input gnt, done, busy, bus_out, bus_oe, CS, AD, WR, RD);
    modport slave  (input req, addr_in, data_in,
                    output gnt, done, busy, bus_out, bus_oe, CS, AD, WR, RD);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first pending request at or after ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N = 6,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    // scan from farthest to nearest so the nearest pending request wins
    always_comb begin
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
        grant = '0;
        grant[idx] = |req;
    end
endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin sharing of the RTC AD bus, one full write cycle per grant
module rtc_bus_arbiter
    import rtc_pkg::*;
#(
    parameter int N_REQ = 6,
    parameter int T_PH = 4
) (
    input logic clk,
    input logic reset,
    rtc_bus_arbiter_if.slave bus
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int PW = $clog2(T_PH) + 1;
    state_t state;
    logic [PW-1:0] cnt;
    logic [IW-1:0] ptr, idx_q, win_idx;
    logic [N_REQ-1:0] win_gnt;
    logic [7:0] addr_q, data_q;
    logic last;
    assign last = cnt == PW'(T_PH - 1);
    rr_arbiter #(.N(N_REQ)) u_arb (.req(bus.req), .ptr(ptr), .grant(win_gnt), .idx(win_idx));
    // outputs are registered for the state being entered, so they change on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            ptr <= '0;
            idx_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            bus.gnt <= '0;
            bus.done <= '0;
            bus.busy <= 1'b0;
            bus.bus_out <= '0;
            bus.bus_oe <= 1'b0;
            bus.CS <= 1'b1;
            bus.AD <= AD_DATA;
            bus.WR <= 1'b1;
            bus.RD <= 1'b1;
        end else begin
            bus.done <= '0;
            bus.RD <= 1'b1;
            if (state == IDLE) begin
                if (|bus.req) begin
                    state <= A_SET;
                    cnt <= '0;
                    idx_q <= win_idx;
                    addr_q <= bus.addr_in[{win_idx, 3'b000} +: 8];
                    data_q <= bus.data_in[{win_idx, 3'b000} +: 8];
                    bus.gnt <= win_gnt;
                    bus.busy <= 1'b1;
                    bus.CS <= 1'b0;
                    bus.AD <= AD_ADDR;
                    bus.bus_oe <= 1'b1;
                    bus.bus_out <= bus.addr_in[{win_idx, 3'b000} +: 8];
                end
            end else if (!last) begin
                cnt <= cnt + PW'(1);
            end else if (state == D_HOLD) begin
                state <= IDLE;
                ptr <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
                bus.done <= bus.gnt;
                bus.gnt <= '0;
                bus.busy <= 1'b0;
                bus.CS <= 1'b1;
                bus.AD <= AD_DATA;
                bus.bus_oe <= 1'b0;
                bus.bus_out <= '0;
                bus.WR <= 1'b1;
            end else begin
                state <= state_t'(state + 3'd1);
                cnt <= '0;
                bus.WR <= !(state == A_SET || state == D_SET);
                if (state == A_HOLD) begin
                    bus.AD <= AD_DATA;
                    bus.bus_out <= data_q;
                end
            end
        end
    end
endmodule
